// File: rtl/nibble_serial_adder64_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit: FSM encodings,
// op encodings and the single-bit full-adder cell used by the 4-bit slice.
package nibble_serial_adder64_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Returns {carry_out, sum} of one full-adder bit.
    function automatic logic [1:0] full_adder_1bit(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/nibble_serial_adder64_adder4.sv
// 4-bit ripple-carry slice built from full-adder cells; the only arithmetic
// resource of the serial unit.
module nibble_serial_adder64_adder4
    import nibble_serial_adder64_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign {c[i+1], sum[i]} = full_adder_1bit(a[i], b[i], c[i]);
    end

    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder64.sv
// Area-reduced WIDTH-bit add/subtract unit: one 4-bit slice is reused over
// WIDTH/4 cycles, with valid/ready handshakes on both sides and C/V/Z flags.
module nibble_serial_adder64
    import nibble_serial_adder64_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);
    localparam logic [CW-1:0] K_LAST = CW'(NIB - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   k;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic            cin_r;

    logic [3:0]      sum4;
    logic            cout4;
    logic            c_msb_in;
    logic [WIDTH-1:0] res_nxt;
    logic            accept, last;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (state == S_RUN) && (k == K_LAST);

    nibble_serial_adder64_adder4 u_adder4 (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (cin_r),
        .sum  (sum4),
        .cout (cout4)
    );

    // Carry into the slice MSB, recovered from its inputs and sum bit.
    assign c_msb_in = a_sh[3] ^ b_sh[3] ^ sum4[3];
    assign res_nxt  = {sum4, res_sh[WIDTH-1:4]};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)    state_nxt = S_RUN;
            S_RUN:   if (last)      state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            k     <= '0;
            cin_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                k     <= '0;
                cin_r <= (op_sub == OP_SUB);
            end else if (state == S_RUN) begin
                k     <= k + CW'(1);
                cin_r <= cout4;
            end
        end
    end

    // Operand shifters and partial-result accumulator carry no reset value.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= a;
            b_sh <= (op_sub == OP_ADD) ? b : ~b;
        end else if (state == S_RUN) begin
            a_sh   <= a_sh >> 4;
            b_sh   <= b_sh >> 4;
            res_sh <= res_nxt;
        end
    end

    // Visible outputs change only when an operation completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (last) begin
            result   <= res_nxt;
            carry    <= cout4;
            overflow <= c_msb_in ^ cout4;
            zero     <= (res_nxt == '0);
        end
    end

endmodule
